// File: rtl/uart_cmd_rx.sv
// UART receive front-end: 2-flop synchroniser, oversampled receiver with
// optional parity, show-ahead RX FIFO, sticky error flags, LED decoder.
// Ports: clk, rst (sync, active-high), rx (serial in, idles high),
//   rd_en/rd_data/rd_valid/fifo_count (FIFO read side),
//   overflow/frame_err/parity_err (sticky, cleared by clr_err),
//   dir_leds (one-hot decode of the last good byte).
module uart_cmd_rx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    input  logic                              rd_en,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    output logic                              frame_err,
    output logic                              parity_err,
    input  logic                              clr_err,
    output logic [3:0]                        dir_leds
);

    localparam int BO  = BAUD * OVERSAMPLE;
    localparam int DIV = (CLK_FREQ_HZ + BO / 2) / BO;
    localparam int DW  = $clog2(DIV);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 sync1, sync2, rx_prev;
    logic                 fall, tick, samp;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tcnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, bad;
    logic                 push_req, ferr_set, perr_set;
    logic [DATA_BITS-1:0] push_byte;
    logic [7:0]           byte8;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 pop, full, wr_ok;

    // Synchroniser flops preset high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign fall = rx_prev & ~sync2;
    assign tick = (div_cnt == DIV_LAST);

    // Restart the divider on a start edge so sampling is phase-aligned
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && fall) || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign samp = tick &&
        (tcnt == ((state == START) ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            bad       <= 1'b0;
            push_req  <= 1'b0;
            push_byte <= '0;
            ferr_set  <= 1'b0;
            perr_set  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            ferr_set <= 1'b0;
            perr_set <= 1'b0;
            if (tick)
                tcnt <= samp ? '0 : tcnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        tcnt    <= '0;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        bad     <= 1'b0;
                    end
                end
                START: begin
                    if (samp)
                        state <= sync2 ? IDLE : DATA;
                end
                DATA: begin
                    if (samp) begin
                        shreg   <= {sync2, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ sync2;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (samp) begin
                        if ((par_acc ^ sync2) != PAR_ODD) begin
                            bad      <= 1'b1;
                            perr_set <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (samp) begin
                        if (!sync2) begin
                            ferr_set <= 1'b1;
                            state    <= WAIT_IDLE;
                        end else begin
                            push_req  <= ~bad;
                            push_byte <= shreg;
                            state     <= IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (sync2)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop   = rd_en & rd_valid;
    assign full  = (count == DEPTH);
    // A pop frees the head slot, so a push into a full FIFO still fits
    assign wr_ok = push_req & (~full | pop);
    assign byte8 = 8'(push_byte);

    function automatic logic [3:0] cmd_decode(input logic [7:0] b);
        case (b)
            8'h55:   return 4'b0001;
            8'h44:   return 4'b0010;
            8'h4C:   return 4'b0100;
            8'h52:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            dir_leds   <= 4'b0000;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow   <= (push_req & full & ~pop) | (overflow & ~clr_err);
            frame_err  <= ferr_set | (frame_err & ~clr_err);
            parity_err <= perr_set | (parity_err & ~clr_err);
            // Dropped-on-overflow bytes still count as good commands
            if (push_req)
                dir_leds <= cmd_decode(byte8);
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: 8N1 instance (u0) and even-parity
// instance (u1), default timing (DIV = 27, 432 clk per bit).
module tb_uart_cmd_rx;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_en2 = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rd_data, rd_data2;
    logic       rd_valid, rd_valid2;
    logic [3:0] fifo_count, fifo_count2;
    logic       overflow, overflow2;
    logic       frame_err, frame_err2;
    logic       parity_err, parity_err2;
    logic [3:0] dir_leds, dir_leds2;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    logic [7:0] drain_exp [8] = '{8'h4C, 8'h52, 8'h41, 8'h01,
                                  8'h02, 8'h03, 8'h04, 8'h4C};

    always #5 clk = ~clk;

    uart_cmd_rx u0 (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .overflow(overflow),
        .frame_err(frame_err), .parity_err(parity_err),
        .clr_err(clr_err), .dir_leds(dir_leds)
    );

    uart_cmd_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .rx(rx2), .rd_en(rd_en2),
        .rd_data(rd_data2), .rd_valid(rd_valid2),
        .fifo_count(fifo_count2), .overflow(overflow2),
        .frame_err(frame_err2), .parity_err(parity_err2),
        .clr_err(clr_err), .dir_leds(dir_leds2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; always entered 1 time unit after a posedge.
    // The stop sample lands on the edge ending stop-bit iteration 218.
    task automatic send(input bit line, input logic [7:0] data,
                        input bit par_en, input bit par_bit,
                        input bit stop_bit, input bit pop_at_push,
                        input int limit, input bit probe);
        logic [10:0] fr;
        int nb;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = data;
        if (par_en) begin
            fr[9] = par_bit;
            fr[10] = stop_bit;
            nb = 11;
        end else begin
            fr[9] = stop_bit;
            nb = 10;
        end
        for (int b = 0; b < nb && b < limit; b++) begin
            if (line) rx2 = fr[b];
            else rx = fr[b];
            for (int i = 0; i < BIT; i++) begin
                @(posedge clk);
                #1;
                if (pop_at_push && b == nb - 1)
                    rd_en = (i == 218);
                if (probe && b == nb - 1 && i == 216)
                    chk("pre_stop_valid", rd_valid, 0);
                if (probe && b == nb - 1 && i == 222)
                    chk("post_stop_valid", rd_valid, 1);
            end
        end
        if (line) rx2 = 1'b1;
        else rx = 1'b1;
    endtask

    task automatic pop1;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic clr;
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(5);
        chk("rst_valid", rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_flags", {overflow, frame_err, parity_err}, 0);
        chk("rst_leds", dir_leds, 0);
        chk("rst_valid2", rd_valid2, 0);
        rst = 1'b0;
        cyc(20);

        send(0, 8'h55, 0, 0, 1, 0, 99, 1);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, 8'h55);
        chk("t1_leds", dir_leds, 4'b0001);
        chk("t1_count", fifo_count, 1);
        pop1();
        chk("t1_pop_valid", rd_valid, 0);
        chk("t1_pop_count", fifo_count, 0);
        rd_en = 1'b1;
        cyc(3);
        rd_en = 1'b0;
        chk("t1_empty_pop", fifo_count, 0);

        send(0, 8'h44, 0, 0, 1, 0, 99, 0);
        send(0, 8'h4C, 0, 0, 1, 0, 99, 0);
        send(0, 8'h52, 0, 0, 1, 0, 99, 0);
        send(0, 8'h41, 0, 0, 1, 0, 99, 0);
        chk("t2_count", fifo_count, 4);
        chk("t2_head", rd_data, 8'h44);
        chk("t2_leds", dir_leds, 4'b0000);

        // Fill to 8, then one extra command byte overflows
        send(0, 8'h01, 0, 0, 1, 0, 99, 0);
        send(0, 8'h02, 0, 0, 1, 0, 99, 0);
        send(0, 8'h03, 0, 0, 1, 0, 99, 0);
        send(0, 8'h04, 0, 0, 1, 0, 99, 0);
        chk("t3_full_count", fifo_count, 8);
        chk("t3_no_ovf", overflow, 0);
        send(0, 8'h44, 0, 0, 1, 0, 99, 0);
        chk("t3_ovf_count", fifo_count, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_ovf_head", rd_data, 8'h44);
        chk("t3_ovf_leds", dir_leds, 4'b0010);
        clr();
        chk("t3_clr", overflow, 0);
        send(0, 8'h4C, 0, 0, 1, 1, 99, 0);
        chk("t3_pp_count", fifo_count, 8);
        chk("t3_pp_ovf", overflow, 0);
        chk("t3_pp_head", rd_data, 8'h4C);
        chk("t3_pp_leds", dir_leds, 4'b0100);

        rx = 1'b0;
        cyc(100);
        rx = 1'b1;
        cyc(600);
        chk("t4_count", fifo_count, 8);
        chk("t4_flags", {overflow, frame_err, parity_err}, 0);

        send(0, 8'h52, 0, 0, 0, 0, 99, 0);
        cyc(10);
        chk("t5_ferr", frame_err, 1);
        chk("t5_count", fifo_count, 8);
        chk("t5_head", rd_data, 8'h4C);
        chk("t5_leds", dir_leds, 4'b0100);
        chk("t5_no_ovf", overflow, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t5_drain%0d", k), rd_data, drain_exp[k]);
            pop1();
        end
        chk("t5_drained", fifo_count, 0);
        send(0, 8'h55, 0, 0, 1, 0, 99, 0);
        chk("t5_rx_count", fifo_count, 1);
        chk("t5_rx_data", rd_data, 8'h55);
        chk("t5_rx_leds", dir_leds, 4'b0001);
        chk("t5_ferr_sticky", frame_err, 1);
        clr();
        chk("t5_ferr_clr", frame_err, 0);

        // 0x07 has three ones: even parity bit must be 1
        send(1, 8'h07, 1, 0, 1, 0, 99, 0);
        cyc(2);
        chk("t6_perr", parity_err2, 1);
        chk("t6_bad_count", fifo_count2, 0);
        send(1, 8'h07, 1, 1, 1, 0, 99, 0);
        chk("t6_good_count", fifo_count2, 1);
        chk("t6_good_data", rd_data2, 8'h07);
        chk("t6_perr_sticky", parity_err2, 1);

        send(1, 8'h52, 1, 0, 1, 0, 4, 0);
        rst = 1'b1;
        cyc(3);
        chk("t6_rst_count2", fifo_count2, 0);
        chk("t6_rst_valid2", rd_valid2, 0);
        chk("t6_rst_data2", rd_data2, 0);
        chk("t6_rst_flags2", {overflow2, frame_err2, parity_err2}, 0);
        chk("t6_rst_leds2", dir_leds2, 0);
        chk("t6_rst_count0", fifo_count, 0);
        chk("t6_rst_leds0", dir_leds, 0);
        rst = 1'b0;
        cyc(20);
        send(1, 8'h55, 1, 0, 1, 0, 99, 0);
        chk("t6_clean_count", fifo_count2, 1);
        chk("t6_clean_data", rd_data2, 8'h55);
        chk("t6_clean_leds", dir_leds2, 4'b0001);
        chk("t6_clean_flags", {overflow2, frame_err2, parity_err2}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Parametrised UART receive front-end: synchronised RX input, oversampled receiver with optional parity, show-ahead receive FIFO, sticky error flags, and the arrow-key command decoder that drives the board LEDs.
- Sits between the board `rx` pin and the CPU/RAM UART data path.
- Adds to the existing single-byte RX path: configurable framing, buffering, overflow/framing/parity detection, and false-start rejection.

Parameters:
- CLK_FREQ_HZ, 50000000: system clock frequency.
- BAUD, 115200: line rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 4.
- DATA_BITS, 8: payload bits per frame. Legal range 5..8.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even. Ignored when PARITY_EN = 0.
- FIFO_DEPTH, 8: receive FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- rd_en  in  1  pop request; honoured only when rd_valid = 1.
- rd_data  out  DATA_BITS  FIFO head (show-ahead).
- rd_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- clr_err  in  1  clears all three sticky flags.
- dir_leds  out  4  one-hot decode of the last good byte.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO empty, FSM in IDLE, synchroniser flops preset to 1.
- Tick generator:
  - DIV = round(CLK_FREQ_HZ / (BAUD*OVERSAMPLE)); with defaults DIV = 27.
  - Free-running counter emits a 1-cycle tick every DIV clocks.
  - Counter is restarted on start-edge detection.
- RX input: 2-flop synchroniser, then falling-edge detect on the synchronised signal.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE → START on a synchronised falling edge.
- START:
  - Samples after OVERSAMPLE/2 ticks (mid-bit).
  - rx = 1 at the sample → false start, back to IDLE, nothing recorded.
  - rx = 0 → DATA.
- DATA:
  - Samples every OVERSAMPLE ticks, LSB first, DATA_BITS samples.
  - Then → PARITY if PARITY_EN, else → STOP.
- PARITY: one sample. XOR(data, parity bit) must be 0 for even parity, 1 for odd; mismatch marks the frame bad and sets parity_err. → STOP.
- STOP:
  - One sample.
  - Sample = 0 → set frame_err, discard the byte, → WAIT_IDLE.
  - Sample = 1 → IDLE. If no parity error, the byte is "good" and is pushed on the next clk.
- WAIT_IDLE → IDLE once synchronised rx = 1; prevents break conditions from retriggering.
- Latency: good byte visible on rd_data/rd_valid 1 clk after the push cycle, i.e. 2 clk after the stop-bit sample.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Pop: rd_en & rd_valid advances the head; new head appears the next clk.
  - rd_en while empty: ignored.
  - Push while full without a same-cycle pop: byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both succeed, count unchanged, no overflow (including when full).
- Sticky flags:
  - Set on their event; cleared by clr_err.
  - clr_err in the same cycle as a new event: the flag stays set.
- dir_leds:
  - Updated 1 clk after every good byte, including bytes dropped by overflow.
  - 0x55 → 0001, 0x44 → 0010, 0x4C → 0100, 0x52 → 1000, any other byte → 0000.
  - Comparison uses the byte zero-extended to 8 bits.
  - Bad frames leave dir_leds unchanged.
- rst asserted mid-frame: frame abandoned, FIFO flushed, FSM → IDLE. Receive resumes on the next falling edge after rst deasserts.

Test Plan:
All scenarios use default parameters: DIV = 27, bit period = 432 clk.
- Send 0x55 (8N1) → rd_valid = 1 with rd_data = 0x55 2 clk after the stop sample; dir_leds = 0001; fifo_count = 1. Pulse rd_en → rd_valid = 0, count = 0.
- Send 0x44, 0x4C, 0x52, 0x41 back-to-back, no reads → FIFO order 44, 4C, 52, 41; count = 4; dir_leds ends 0000 (0x41 is not a command byte).
- Send 9 bytes 0x01..0x09 with no reads → count = 8; 0x09 dropped; overflow = 1; head = 0x01. Pulse clr_err → overflow = 0. Repeat with rd_en asserted in the push cycle of the 9th byte → overflow stays 0, count stays 8.
- Drive rx low for 100 clk, then high → no byte received, no flags set, FSM back in IDLE.
- Send 0x52 with the stop bit forced low → frame_err = 1, FIFO unchanged, dir_leds unchanged. Then send 0x55 → received normally.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 → parity_err = 1, not pushed. Resend with parity bit 1 → pushed. Then assert rst mid-frame → all outputs 0, next frame received cleanly.
